// File: rtl/stall_detection.sv
// -----------------------------------------------------------------------------
// stall_detection
//
// Hazard detector for a 5-stage MIPS-subset pipeline (LW, SW, R-type, BEQ, J,
// ADDI). It compares opcodes and register fields across the ID, EX and MEM
// stages and produces two independent stall requests:
//   IDstall : a BEQ in ID needs an operand that is not yet available in ID
//             (branches resolve in ID, so they cannot use EX/MEM forwarding).
//   EXstall : a load in MEM feeds an instruction in EX (load-use) in a way
//             that forwarding cannot cover.
// Two saturating counters record how many cycles each stall was high.
//
// Ports
//   EXop, EXrd, EXrs, EXrt  in   opcode/rd/rs/rt of the EX instruction
//   IDop, IDrs, IDrt        in   opcode/rs/rt of the ID instruction
//   MEMop, MEMrt            in   opcode/rt of the MEM instruction
//   IDstall                 out  freeze PC/IF/ID, bubble into EX (comb.)
//   EXstall                 out  freeze PC/IF/ID/EX, bubble into MEM (comb.)
//   clk                     in   clock; counters update on the rising edge
//   reset                   in   synchronous, active-high; clears counters
//   id_stall_count          out  CNT_W-bit count of cycles with IDstall high
//   ex_stall_count          out  CNT_W-bit count of cycles with EXstall high
//
// Parameters
//   CNT_W  width of each stall counter (default 16)
//
// Build option
//   ZERO_REG_FILTER_EN  when defined, a match on register 0 never stalls,
//                       because $zero is never written. When undefined,
//                       register 0 is compared like any other register.
// -----------------------------------------------------------------------------
module stall_detection #(
  parameter int CNT_W = 16
) (
  input  logic [5:0]       EXop,
  input  logic [4:0]       EXrd,
  input  logic [4:0]       EXrs,
  input  logic [4:0]       EXrt,
  input  logic [5:0]       IDop,
  input  logic [4:0]       IDrs,
  input  logic [4:0]       IDrt,
  input  logic [5:0]       MEMop,
  input  logic [4:0]       MEMrt,
  output logic             IDstall,
  output logic             EXstall,
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] id_stall_count,
  output logic [CNT_W-1:0] ex_stall_count
);

  // ---------------------------------------------------------------------------
  // Opcodes
  // ---------------------------------------------------------------------------
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Register-field comparison. With the filter enabled, a producer whose
  // destination is $zero can never create a real dependency.
  // ---------------------------------------------------------------------------
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
`ifdef ZERO_REG_FILTER_EN
    return (a == b) && (a != 5'd0);
`else
    return (a == b);
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  logic w_id_is_beq;
  logic w_ex_is_rtype;
  logic w_ex_is_lw;
  logic w_ex_is_sw;
  logic w_ex_is_addi;
  logic w_mem_is_lw;

  assign w_id_is_beq   = (IDop  == OP_BEQ);
  assign w_ex_is_rtype = (EXop  == OP_RTYPE);
  assign w_ex_is_lw    = (EXop  == OP_LW);
  assign w_ex_is_sw    = (EXop  == OP_SW);
  assign w_ex_is_addi  = (EXop  == OP_ADDI);
  assign w_mem_is_lw   = (MEMop == OP_LW);

  // ---------------------------------------------------------------------------
  // ID-stage branch hazard.
  // The destination of an R-type is rd; LW and ADDI write rt. J, SW and BEQ
  // write nothing, so they never appear as producers here. A load in MEM has
  // not returned its data in time for a branch comparing in ID.
  // ---------------------------------------------------------------------------
  logic w_ex_rtype_hit;
  logic w_ex_itype_hit;
  logic w_mem_load_hit;

  assign w_ex_rtype_hit = w_ex_is_rtype &&
                          (reg_match(EXrd, IDrs) || reg_match(EXrd, IDrt));
  assign w_ex_itype_hit = (w_ex_is_lw || w_ex_is_addi) &&
                          (reg_match(EXrt, IDrs) || reg_match(EXrt, IDrt));
  assign w_mem_load_hit = w_mem_is_lw &&
                          (reg_match(MEMrt, IDrs) || reg_match(MEMrt, IDrt));

  assign IDstall = w_id_is_beq &&
                   (w_ex_rtype_hit || w_ex_itype_hit || w_mem_load_hit);

  // ---------------------------------------------------------------------------
  // EX-stage load-use hazard.
  // R-type reads both rs and rt in EX. LW, SW and ADDI read only rs in EX as
  // the address/operand; SW's rt is store data, which is consumed in MEM and
  // can be forwarded from the load there, so it is deliberately excluded.
  // ---------------------------------------------------------------------------
  logic w_lu_rtype_hit;
  logic w_lu_base_hit;

  assign w_lu_rtype_hit = w_ex_is_rtype &&
                          (reg_match(MEMrt, EXrs) || reg_match(MEMrt, EXrt));
  assign w_lu_base_hit  = (w_ex_is_lw || w_ex_is_sw || w_ex_is_addi) &&
                          reg_match(MEMrt, EXrs);

  assign EXstall = w_mem_is_lw && (w_lu_rtype_hit || w_lu_base_hit);

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counters. Reset wins over increment.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_id_stall_count;
  logic [CNT_W-1:0] r_ex_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_stall_count <= '0;
    end else if (IDstall && (r_id_stall_count != CNT_MAX)) begin
      r_id_stall_count <= r_id_stall_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_stall_count <= '0;
    end else if (EXstall && (r_ex_stall_count != CNT_MAX)) begin
      r_ex_stall_count <= r_ex_stall_count + CNT_ONE;
    end
  end

  assign id_stall_count = r_id_stall_count;
  assign ex_stall_count = r_ex_stall_count;

endmodule

// File: tb/tb_stall_detection.sv
// -----------------------------------------------------------------------------
// tb_stall_detection
// Self-checking bench for stall_detection. Inputs change on the falling edge;
// the combinational stalls are sampled 1 ns later and the counters are sampled
// on falling edges, well away from the rising edge that updates them.
// Expected stall pairs {IDstall, EXstall} are pushed to exp_q as each vector is
// driven and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_stall_detection;

  localparam int CNT_W = 16;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic             clk;
  logic             reset;
  logic [5:0]       EXop;
  logic [4:0]       EXrd;
  logic [4:0]       EXrs;
  logic [4:0]       EXrt;
  logic [5:0]       IDop;
  logic [4:0]       IDrs;
  logic [4:0]       IDrt;
  logic [5:0]       MEMop;
  logic [4:0]       MEMrt;
  logic             IDstall;
  logic             EXstall;
  logic [CNT_W-1:0] id_stall_count;
  logic [CNT_W-1:0] ex_stall_count;

  logic [1:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  stall_detection #(.CNT_W(CNT_W)) dut (
    .EXop           (EXop),
    .EXrd           (EXrd),
    .EXrs           (EXrs),
    .EXrt           (EXrt),
    .IDop           (IDop),
    .IDrs           (IDrs),
    .IDrt           (IDrt),
    .MEMop          (MEMop),
    .MEMrt          (MEMrt),
    .IDstall        (IDstall),
    .EXstall        (EXstall),
    .clk            (clk),
    .reset          (reset),
    .id_stall_count (id_stall_count),
    .ex_stall_count (ex_stall_count)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_baseline();
    EXop  = OP_RTYPE; IDop = OP_RTYPE; MEMop = OP_RTYPE;
    EXrd  = 5'd1; EXrs = 5'd2; EXrt = 5'd3;
    IDrs  = 5'd4; IDrt = 5'd5; MEMrt = 5'd6;
  endtask

  // Vector that raises both stalls at once.
  task automatic set_both_stall();
    set_baseline();
    IDop  = OP_BEQ;
    EXop  = OP_LW; EXrt = 5'd21; IDrs = 5'd21;
    MEMop = OP_LW; MEMrt = 5'd7; EXrs = 5'd7;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [1:0] got, exp;
    reset = 1'b1;
    set_baseline();
    exp_q.push_back(2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (id_stall_count !== 16'd0) begin
      $display("FAIL reset_id_count: got %0d expected 0", id_stall_count); n_fail++;
    end
    n_checks++;
    if (ex_stall_count !== 16'd0) begin
      $display("FAIL reset_ex_count: got %0d expected 0", ex_stall_count); n_fail++;
    end
    #1;
    got = {IDstall, EXstall};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      $display("FAIL baseline: got %b expected %b", got, exp); n_fail++;
    end
  endtask

  task automatic test_branch_hazard();
    logic [1:0] got, exp;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      set_baseline();
      IDop = OP_BEQ;
      case (k)
        0: begin EXrd = 5'd21; IDrs = 5'd21; end
        1: begin EXrd = 5'd21; IDrt = 5'd21; end
        2: begin EXop = OP_LW;   EXrt = 5'd21; IDrs = 5'd21; end
        3: begin EXop = OP_LW;   EXrt = 5'd21; IDrt = 5'd21; end
        4: begin EXop = OP_ADDI; EXrt = 5'd21; IDrs = 5'd21; end
        5: begin EXop = OP_ADDI; EXrt = 5'd21; IDrt = 5'd21; end
        6: begin MEMop = OP_LW;  MEMrt = 5'd21; IDrs = 5'd21; end
        default: begin MEMop = OP_LW; MEMrt = 5'd21; IDrt = 5'd21; end
      endcase
      exp_q.push_back(2'b10);
      #1;
      got = {IDstall, EXstall};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        $display("FAIL branch_%0d: got %b expected %b", k, got, exp); n_fail++;
      end
    end
  endtask

  task automatic test_load_use();
    logic [1:0] got, exp;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_baseline();
      MEMop = OP_LW; MEMrt = 5'd21;
      case (k)
        0: EXrs = 5'd21;
        1: EXrt = 5'd21;
        2: begin EXop = OP_LW;   EXrs = 5'd21; end
        3: begin EXop = OP_SW;   EXrs = 5'd21; end
        default: begin EXop = OP_ADDI; EXrs = 5'd21; end
      endcase
      exp_q.push_back(2'b01);
      #1;
      got = {IDstall, EXstall};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        $display("FAIL load_use_%0d: got %b expected %b", k, got, exp); n_fail++;
      end
    end
  endtask

  task automatic test_negative();
    logic [1:0] got, exp;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      set_baseline();
      case (k)
        0: begin EXop = OP_SW; EXrt = 5'd21; MEMrt = 5'd21; MEMop = OP_LW; end
        1: begin EXrd = 5'd21; IDrs = 5'd21; end
        2: begin MEMop = OP_ADDI; MEMrt = 5'd21; EXrs = 5'd21; end
        3: begin IDop = OP_BEQ; EXop = OP_J;   EXrt = 5'd21; EXrd = 5'd21; IDrs = 5'd21; end
        4: begin IDop = OP_BEQ; EXop = OP_SW;  EXrt = 5'd21; IDrs = 5'd21; end
        5: begin IDop = OP_BEQ; MEMop = OP_SW; MEMrt = 5'd21; IDrt = 5'd21; end
        default: begin EXop = OP_BEQ; MEMop = OP_LW; MEMrt = 5'd21; EXrs = 5'd21; end
      endcase
      exp_q.push_back(2'b00);
      #1;
      got = {IDstall, EXstall};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        $display("FAIL negative_%0d: got %b expected %b", k, got, exp); n_fail++;
      end
    end
  endtask

  task automatic test_both_stall();
    logic [1:0] got, exp;
    @(negedge clk);
    set_both_stall();
    exp_q.push_back(2'b11);
    #1;
    got = {IDstall, EXstall};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      $display("FAIL both_stall: got %b expected %b", got, exp); n_fail++;
    end
  endtask

  task automatic test_zero_reg();
    logic [1:0] got, exp;
    @(negedge clk);
    set_baseline();
    IDop = OP_BEQ; EXrd = 5'd0; IDrs = 5'd0;
`ifdef ZERO_REG_FILTER_EN
    exp_q.push_back(2'b00);
`else
    exp_q.push_back(2'b10);
`endif
    #1;
    got = {IDstall, EXstall};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      $display("FAIL zero_reg: got %b expected %b", got, exp); n_fail++;
    end
  endtask

  task automatic test_counters();
    // Clear, then five cycles of IDstall only.
    @(negedge clk);
    set_baseline();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    IDop = OP_BEQ; EXrd = 5'd21; IDrs = 5'd21;
    repeat (5) @(negedge clk);
    set_baseline();
    n_checks++;
    if (id_stall_count !== 16'd5) begin
      $display("FAIL id_count_5: got %0d expected 5", id_stall_count); n_fail++;
    end
    n_checks++;
    if (ex_stall_count !== 16'd0) begin
      $display("FAIL ex_count_0: got %0d expected 0", ex_stall_count); n_fail++;
    end
    // Idle cycle must not move the counter.
    @(negedge clk);
    n_checks++;
    if (id_stall_count !== 16'd5) begin
      $display("FAIL id_count_hold: got %0d expected 5", id_stall_count); n_fail++;
    end
    // Three cycles of EXstall only.
    MEMop = OP_LW; MEMrt = 5'd21; EXrs = 5'd21;
    repeat (3) @(negedge clk);
    set_baseline();
    n_checks++;
    if (ex_stall_count !== 16'd3) begin
      $display("FAIL ex_count_3: got %0d expected 3", ex_stall_count); n_fail++;
    end
    // Reset for one edge while both stalls are high: reset wins.
    set_both_stall();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_baseline();
    n_checks++;
    if (id_stall_count !== 16'd0) begin
      $display("FAIL reset_prio_id: got %0d expected 0", id_stall_count); n_fail++;
    end
    n_checks++;
    if (ex_stall_count !== 16'd0) begin
      $display("FAIL reset_prio_ex: got %0d expected 0", ex_stall_count); n_fail++;
    end
    // Drive both counters up to 0xFFFE, then three more stall cycles.
    set_both_stall();
    repeat (65534) @(negedge clk);
    n_checks++;
    if (id_stall_count !== 16'hFFFE) begin
      $display("FAIL id_count_fffe: got %h expected fffe", id_stall_count); n_fail++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (id_stall_count !== 16'hFFFF) begin
      $display("FAIL id_count_sat: got %h expected ffff", id_stall_count); n_fail++;
    end
    n_checks++;
    if (ex_stall_count !== 16'hFFFF) begin
      $display("FAIL ex_count_sat: got %h expected ffff", ex_stall_count); n_fail++;
    end
    set_baseline();
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set_baseline();
    test_reset();
    test_branch_hazard();
    test_load_use();
    test_negative();
    test_both_stall();
    test_zero_reg();
    test_counters();
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); n_fail++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
